// File: rtl/c2_fp_pkg.sv
// Shared FP constants and the requester tag that travels alongside each divide.
package c2_fp_pkg;
  localparam int FPDIV_LAT = 9;
  localparam int FP_W      = 32;
  localparam int TAG_IDW   = 3;   // wide enough for the largest requester count (8)

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping; one-hot grant plus index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && eligible[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = j;
      end
    end
  end
endmodule

// File: rtl/fpdiv_sched.sv
// Shares one pipelined fpdiv among NREQ requesters: round-robin issue, tag pipe carrying owner IDs,
// per-requester outstanding limits, and an in-order result strobe.
module fpdiv_sched
  import c2_fp_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = FPDIV_LAT,
  parameter int MAXOUT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [FP_W*NREQ-1:0]    req_a,
  input  logic [FP_W*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [FP_W-1:0]         div_a,
  output logic [FP_W-1:0]         div_b,
  input  logic [FP_W-1:0]         div_res,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [FP_W-1:0]         res_data,
  output logic                    idle
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]      ptr_reg;
  logic [IW-1:0]      grant_idx;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    cnt_zero;
  logic [FP_W-1:0]    op_a [NREQ];
  logic [FP_W-1:0]    op_b [NREQ];
  tag_t               tag_reg [DIV_LAT+1];
  logic               transfer;
  logic               pipe_busy;
  logic [FP_W-1:0]    div_a_reg, div_b_reg, res_data_reg;
  logic               res_valid_reg;
  logic [TAG_IDW-1:0] res_id_reg;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [3:0] cnt_reg;
      logic       inc, dec;

      assign op_a[gi]     = req_a[gi*FP_W +: FP_W];
      assign op_b[gi]     = req_b[gi*FP_W +: FP_W];
      assign eligible[gi] = req_valid[gi] && (cnt_reg < 4'(MAXOUT));
      assign cnt_zero[gi] = (cnt_reg == 4'd0);
      assign inc          = transfer && grant[gi];
      assign dec          = res_valid_reg && (res_id_reg == TAG_IDW'(gi));

      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg <= '0;
        else if (inc && !dec)
          cnt_reg <= cnt_reg + 4'd1;
        else if (dec && !inc)
          cnt_reg <= cnt_reg - 4'd1;
      end

      // A retire with nothing outstanding means a result arrived that was never issued.
      a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(dec && !inc && cnt_reg == 4'd0));
    end
  endgenerate

  rr_arbiter #(.N(NREQ)) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? '0 : grant;
  assign transfer  = |req_ready;

  // Tag pipe never stalls: the divider is fully pipelined and results have no backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= DIV_LAT; k++) tag_reg[k] <= '0;
    end else begin
      tag_reg[0] <= '{valid: transfer, id: TAG_IDW'(grant_idx)};
      for (int k = 1; k <= DIV_LAT; k++) tag_reg[k] <= tag_reg[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      div_a_reg     <= '0;
      div_b_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      res_data_reg  <= '0;
    end else begin
      res_valid_reg <= tag_reg[DIV_LAT].valid;
      if (tag_reg[DIV_LAT].valid) begin
        res_id_reg   <= tag_reg[DIV_LAT].id;
        res_data_reg <= div_res;
      end
      if (transfer) begin
        div_a_reg <= op_a[grant_idx];
        div_b_reg <= op_b[grant_idx];
        ptr_reg   <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k <= DIV_LAT; k++) pipe_busy = pipe_busy | tag_reg[k].valid;
  end

  assign div_a     = div_a_reg;
  assign div_b     = div_b_reg;
  assign res_valid = res_valid_reg;
  assign res_id    = res_id_reg[IW-1:0];
  assign res_data  = res_data_reg;
  assign idle      = (&cnt_zero) && !pipe_busy && !res_valid_reg;
endmodule
